// File: rtl/fb_write_scheduler.sv
// Single-port frame-buffer arbiter: VGA reads always win; a latched UART row drains
// into RAM one 24-bit word per idle cycle. Rejected rows raise sticky flags and a counter.
module fb_write_scheduler #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int PIX_BITS     = 3,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             row_valid,
    input  logic [8:0]                       row_idx,
    input  logic [PIX_BITS*WIDTH-1:0]        row_data,
    input  logic                             rd_req,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [PIX_BITS*PIX_PER_WORD-1:0] rd_data,
    output logic                             rd_valid,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [PIX_BITS*PIX_PER_WORD-1:0] mem_wdata,
    input  logic [PIX_BITS*PIX_PER_WORD-1:0] mem_rdata,
    output logic                             busy,
    output logic                             row_done,
    output logic                             overrun,
    output logic                             range_err,
    output logic [7:0]                       drop_cnt,
    input  logic                             clr_err
);
    localparam int WORD_W        = PIX_BITS * PIX_PER_WORD;
    localparam int WORDS_PER_ROW = WIDTH / PIX_PER_WORD;
    localparam int IDX_W         = $clog2(WORDS_PER_ROW);
    localparam int LSB_W         = $clog2(PIX_BITS * WIDTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_ROW - 1);
    localparam logic [8:0]       ROW_LIMIT = 9'(HEIGHT);

    logic [0:0]                r_state;
    logic [PIX_BITS*WIDTH-1:0] r_shadow;
    logic [ADDR_W-1:0]         r_base;
    logic [IDX_W-1:0]          r_word_idx;
    logic                      r_mem_en;
    logic                      r_mem_we;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [WORD_W-1:0]         r_mem_wdata;
    logic                      r_rd_p1;
    logic                      r_rd_valid;
    logic                      r_row_done;
    logic                      r_overrun;
    logic                      r_range_err;
    logic [7:0]                r_drop_cnt;

    logic [ADDR_W-1:0] w_row_base;
    logic [LSB_W-1:0]  w_word_lsb;
    logic [WORD_W-1:0] w_word;
    logic              w_write_issue;
    logic              w_last_word;
    logic              w_accept;
    logic              w_overrun_ev;
    logic              w_range_ev;

    // row_idx*80 as two shifts; fits ADDR_W for every legal row
    assign w_row_base    = (ADDR_W'(row_idx) << 6) + (ADDR_W'(row_idx) << 4);
    assign w_word_lsb    = LSB_W'(r_word_idx) * LSB_W'(WORD_W);
    assign w_word        = r_shadow[w_word_lsb +: WORD_W];

    assign w_write_issue = (r_state == S_WRITE) && !rd_req;
    assign w_last_word   = w_write_issue && (r_word_idx == LAST_WORD);
    assign w_accept      = row_valid && (r_state == S_IDLE) && (row_idx < ROW_LIMIT);
    assign w_overrun_ev  = row_valid && (r_state == S_WRITE);
    assign w_range_ev    = row_valid && (r_state == S_IDLE) && (row_idx >= ROW_LIMIT);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow <= row_data;
            r_base   <= w_row_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word_idx  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_p1     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_row_done  <= 1'b0;
            r_overrun   <= 1'b0;
            r_range_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_row_done <= 1'b0;
            r_rd_p1    <= rd_req;
            r_rd_valid <= r_rd_p1;

            if (rd_req) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= rd_addr;
            end else if (w_write_issue) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_base + ADDR_W'(r_word_idx);
                r_mem_wdata <= w_word;
                r_word_idx  <= r_word_idx + IDX_W'(1);
                if (w_last_word) begin
                    r_state    <= S_IDLE;
                    r_row_done <= 1'b1;
                end
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end

            if (w_accept) begin
                r_state    <= S_WRITE;
                r_word_idx <= '0;
            end

            // clear has priority over any same-edge rejection
            if (clr_err) begin
                r_overrun   <= 1'b0;
                r_range_err <= 1'b0;
                r_drop_cnt  <= '0;
            end else begin
                if (w_overrun_ev)
                    r_overrun <= 1'b1;
                if (w_range_ev)
                    r_range_err <= 1'b1;
                if ((w_overrun_ev || w_range_ev) && (r_drop_cnt != 8'hFF))
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign rd_data   = mem_rdata;
    assign rd_valid  = r_rd_valid;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == S_WRITE);
    assign row_done  = r_row_done;
    assign overrun   = r_overrun;
    assign range_err = r_range_err;
    assign drop_cnt  = r_drop_cnt;
endmodule
